call_request_queue: RTL and testbench

CALL_REQUEST_QUEUE -- requirements
Module: call_request_queue

---
 rtl/elevator_pkg.sv | 34 +++
 rtl/btn_debounce.sv | 48 ++++
 rtl/call_request_queue.sv | 150 +++++++++++++++
 tb/tb_call_request_queue.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared floor encodings, arbiter state type and small floor helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package elevator_pkg;

    typedef logic [1:0] floor_t;

    localparam floor_t GROUND     = 2'd0;
    localparam floor_t FIRST      = 2'd1;
    localparam floor_t SECOND     = 2'd2;
    localparam floor_t FLOOR_NONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    // Absolute floor distance; only meaningful for real floors (0..2).
    function automatic logic [1:0] floor_dist(input floor_t a, input floor_t b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // One-hot floor mask {second, first, ground}; FLOOR_NONE maps to no floor.
    function automatic logic [2:0] floor_onehot(input floor_t f);
        case (f)
            GROUND:  return 3'b001;
            FIRST:   return 3'b010;
            SECOND:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, rising-edge pulse.
// Latency: o_rise is high for one cycle, DEBOUNCE_CYCLES+2 edges after i_btn rises.
// Backpressure: none; pulses are single-cycle and must be consumed when high.
// Ports: clk, reset (async active-high), i_btn (raw async level), o_rise (pulse).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_rise
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_d;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // Count consecutive cycles the synchronized input disagrees with the
            // accepted level; any agreement restarts the count.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_rise = r_level & ~r_level_d;

endmodule

// File: rtl/call_request_queue.sv
// Hall-call queue: debounced buttons -> pending calls -> one-at-a-time floor request.
// Latency: pending sets DEBOUNCE_CYCLES+3 edges after a press; request pulses one edge later.
// Backpressure: requests only issue while car_idle; unserved requests reissue after TIMEOUT_CYCLES.
// Ports: clk, reset (async active-high); btn_g/btn_f/btn_s/btn_emerg raw buttons;
//        car_floor/car_idle car status; g_f/f_f/s_f one-cycle floor request;
//        emerg_in latched emergency; pending {second, first, ground} outstanding calls.
module call_request_queue
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_g,
    input  logic       btn_f,
    input  logic       btn_s,
    input  logic       btn_emerg,
    input  logic [1:0] car_floor,
    input  logic       car_idle,
    output logic       g_f,
    output logic       f_f,
    output logic       s_f,
    output logic       emerg_in,
    output logic [2:0] pending
);

    localparam int TCW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t     r_state;
    floor_t         r_target;
    logic [2:0]     r_req;
    logic [TCW-1:0] r_tcnt;
    logic [2:0]     r_pending;
    logic           r_emerg;

    logic [2:0]     w_press;
    logic           w_emerg_rise;
    logic           w_emerg_next;
    logic [2:0]     w_service;
    logic [2:0]     w_pend_eff;
    floor_t         w_sel;
    logic [1:0]     w_best;
    logic [1:0]     w_dist;
    logic           w_found;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_g (
        .clk(clk), .reset(reset), .i_btn(btn_g), .o_rise(w_press[0])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_f (
        .clk(clk), .reset(reset), .i_btn(btn_f), .o_rise(w_press[1])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_s (
        .clk(clk), .reset(reset), .i_btn(btn_s), .o_rise(w_press[2])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_e (
        .clk(clk), .reset(reset), .i_btn(btn_emerg), .o_rise(w_emerg_rise)
    );

    assign w_emerg_next = r_emerg ^ w_emerg_rise;

    // A call at the floor where the car sits idle is serviced on this edge.
    assign w_service  = car_idle ? floor_onehot(car_floor) : 3'b000;
    // Never arbitrate for a call that is being cleared on this same edge.
    assign w_pend_eff = r_pending & ~w_service;

    // Nearest pending floor; ascending scan with strict '<' gives ties to the
    // lower floor. With the car in motion all distances are equal, so the
    // lowest pending floor wins.
    always_comb begin
        w_sel   = GROUND;
        w_best  = 2'd3;
        w_dist  = 2'd0;
        w_found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (w_pend_eff[i]) begin
                w_dist = (car_floor == FLOOR_NONE) ? 2'd0 : floor_dist(floor_t'(i), car_floor);
                if (!w_found || (w_dist < w_best)) begin
                    w_found = 1'b1;
                    w_best  = w_dist;
                    w_sel   = floor_t'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_target  <= GROUND;
            r_req     <= 3'b000;
            r_tcnt    <= '0;
            r_pending <= 3'b000;
            r_emerg   <= 1'b0;
        end else begin
            r_emerg <= w_emerg_next;

            // Service clears after the OR so a same-edge press of a serviced floor is dropped.
            if (w_emerg_next) begin
                r_pending <= 3'b000;
            end else begin
                r_pending <= (r_pending | w_press) & ~w_service;
            end

            if (w_emerg_next) begin
                r_state <= ST_IDLE;
                r_req   <= 3'b000;
                r_tcnt  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_req <= 3'b000;
                        if ((|w_pend_eff) && car_idle) begin
                            r_state  <= ST_ISSUE;
                            r_target <= w_sel;
                            r_req    <= floor_onehot(w_sel);
                        end
                    end
                    ST_ISSUE: begin
                        r_req   <= 3'b000;
                        r_tcnt  <= '0;
                        r_state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        r_req <= 3'b000;
                        if (car_idle && (car_floor == r_target)) begin
                            r_state <= ST_IDLE;
                        end else if (r_tcnt >= TCW'(TIMEOUT_CYCLES - 1)) begin
                            // Give up; the pending bit is kept so IDLE reissues it.
                            r_state <= ST_IDLE;
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_req   <= 3'b000;
                    end
                endcase
            end
        end
    end

    assign g_f      = r_req[0];
    assign f_f      = r_req[1];
    assign s_f      = r_req[2];
    assign emerg_in = r_emerg;
    assign pending  = r_pending;

endmodule

// File: tb/tb_call_request_queue.sv
module tb_call_request_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_g, btn_f, btn_s, btn_emerg;
    logic [1:0] car_floor;
    logic       car_idle;
    logic       g_f, f_f, s_f, emerg_in;
    logic [2:0] pending;
    logic [2:0] req;
    logic [2:0] acc_p;
    logic [2:0] acc_r;

    int n_pass  = 0;
    int n_total = 0;

    call_request_queue #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset),
        .btn_g(btn_g), .btn_f(btn_f), .btn_s(btn_s), .btn_emerg(btn_emerg),
        .car_floor(car_floor), .car_idle(car_idle),
        .g_f(g_f), .f_f(f_f), .s_f(s_f),
        .emerg_in(emerg_in), .pending(pending)
    );

    always #5 clk = ~clk;

    assign req = {s_f, f_f, g_f};

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b1;
        btn_g = 1'b0; btn_f = 1'b0; btn_s = 1'b0; btn_emerg = 1'b0;
        car_floor = 2'd0; car_idle = 1'b1;
        repeat (3) step();
        chk("rst_pending", 8'(pending), 8'h0);
        chk("rst_req", 8'(req), 8'h0);
        chk("rst_emerg", 8'(emerg_in), 8'h0);

        // First-floor call from the ground floor.
        reset = 1'b0;
        btn_f = 1'b1;
        repeat (6) step();
        chk("f_edge6_pending", 8'(pending), 8'h0);
        step();
        chk("f_edge7_pending", 8'(pending), 8'h2);
        chk("f_edge7_req", 8'(req), 8'h0);
        step();
        chk("f_edge8_issue", 8'(req), 8'h2);
        step();
        chk("f_edge9_req_low", 8'(req), 8'h0);
        step();
        btn_f = 1'b0;
        car_floor = 2'd1;
        step();
        chk("f_serviced", 8'(pending), 8'h0);
        acc_r = '0;
        repeat (10) begin step(); acc_r |= req; end
        chk("after_service_no_req", 8'(acc_r), 8'h0);

        // Press for the floor the car idles at is ignored.
        acc_p = '0; acc_r = '0;
        btn_f = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 8) btn_f = 1'b0;
            step();
            acc_p |= pending;
            acc_r |= req;
        end
        chk("same_floor_pending", 8'(acc_p), 8'h0);
        chk("same_floor_req", 8'(acc_r), 8'h0);
        repeat (8) step();

        // Simultaneous ground + second press from first floor: tie to ground.
        btn_g = 1'b1; btn_s = 1'b1;
        repeat (7) step();
        chk("gs_pending", 8'(pending), 8'h5);
        step();
        chk("tie_ground_issue", 8'(req), 8'h1);
        step();
        chk("tie_issue_one_cycle", 8'(req), 8'h0);
        btn_g = 1'b0; btn_s = 1'b0;
        car_floor = 2'd0;
        step();
        chk("g_serviced_pending", 8'(pending), 8'h4);
        step();
        chk("s_issue", 8'(req), 8'h4);
        step();
        chk("s_issue_one_cycle", 8'(req), 8'h0);

        // Car never reaches second floor: 64 WAIT cycles, then reissue.
        acc_r = '0;
        repeat (63) begin step(); acc_r |= req; end
        chk("wait_no_reissue", 8'(acc_r), 8'h0);
        step();
        chk("timeout_idle_req", 8'(req), 8'h0);
        chk("timeout_keeps_pending", 8'(pending), 8'h4);
        step();
        chk("s_reissued", 8'(req), 8'h4);

        // Emergency toggles on with pending=110.
        btn_f = 1'b1;
        repeat (7) step();
        chk("pend_110", 8'(pending), 8'h6);
        btn_f = 1'b0;
        btn_emerg = 1'b1;
        repeat (6) step();
        chk("emerg_edge6", 8'(emerg_in), 8'h0);
        step();
        chk("emerg_on", 8'(emerg_in), 8'h1);
        chk("emerg_clears_pending", 8'(pending), 8'h0);
        acc_p = '0; acc_r = '0;
        btn_s = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) btn_emerg = 1'b0;
            if (i == 9) btn_s = 1'b0;
            step();
            acc_p |= pending;
            acc_r |= req;
        end
        chk("emerg_blocks_pending", 8'(acc_p), 8'h0);
        chk("emerg_blocks_req", 8'(acc_r), 8'h0);
        repeat (6) step();
        btn_emerg = 1'b1;
        repeat (6) step();
        chk("emerg_still_on", 8'(emerg_in), 8'h1);
        step();
        chk("emerg_off", 8'(emerg_in), 8'h0);
        btn_emerg = 1'b0;
        acc_p = '0; acc_r = '0;
        repeat (10) begin step(); acc_p |= pending; acc_r |= req; end
        chk("post_emerg_pending", 8'(acc_p), 8'h0);
        chk("post_emerg_req", 8'(acc_r), 8'h0);

        // 3-cycle glitch rejected, 4-cycle press accepted.
        btn_s = 1'b1;
        repeat (3) step();
        btn_s = 1'b0;
        repeat (8) step();
        chk("glitch_3cyc", 8'(pending), 8'h0);
        btn_s = 1'b1;
        repeat (4) step();
        btn_s = 1'b0;
        repeat (2) step();
        chk("pulse4_edge6", 8'(pending), 8'h0);
        step();
        chk("pulse4_edge7", 8'(pending), 8'h4);
        step();
        chk("pulse4_issue", 8'(req), 8'h4);
        step();
        chk("pulse4_wait_req", 8'(req), 8'h0);

        // Asynchronous reset while waiting.
        #2 reset = 1'b1;
        #1;
        chk("async_rst_pending", 8'(pending), 8'h0);
        chk("async_rst_req", 8'(req), 8'h0);
        chk("async_rst_emerg", 8'(emerg_in), 8'h0);
        @(negedge clk);
        reset = 1'b0;
        acc_p = '0; acc_r = '0;
        repeat (10) begin step(); acc_p |= pending; acc_r |= req; end
        chk("post_rst_pending", 8'(acc_p), 8'h0);
        chk("post_rst_req", 8'(acc_r), 8'h0);

        // Car moving (floor 3): lowest pending floor chosen.
        car_floor = 2'd3;
        btn_f = 1'b1; btn_s = 1'b1;
        repeat (7) step();
        chk("moving_pending", 8'(pending), 8'h6);
        step();
        chk("moving_lowest_issue", 8'(req), 8'h2);
        btn_f = 1'b0; btn_s = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
